// File: rtl/distcalc_multi_pkg.sv
// Shared encodings and width helpers for the multi-mode distance unit.
package distcalc_multi_pkg;

    // Distance metric selected on the first beat of a vector.
    typedef enum logic [1:0] {
        DM_SQEUCLID  = 2'b00,
        DM_MANHATTAN = 2'b01,
        DM_EUCLID    = 2'b10,
        DM_CHEBYSHEV = 2'b11
    } dm_mode_e;

    // Top-level control states.
    typedef enum logic [1:0] {
        ST_ACC   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_SQRT  = 2'b10,
        ST_OUT   = 2'b11
    } dm_state_e;

    // Accumulator width: a full square per lane, summed over every lane of every beat.
    function automatic int unsigned acc_width(input int unsigned vw, input int unsigned lanes,
                                              input int unsigned chunks);
        return 2 * vw + $clog2(lanes * chunks);
    endfunction

    // Root width for an integer square root of an aw-bit operand.
    function automatic int unsigned sqrt_width(input int unsigned aw);
        return (aw + 1) / 2;
    endfunction

endpackage

// File: rtl/distcalc_multi_isqrt_seq.sv
// Sequential restoring integer square root: floor(sqrt(op_i)), one root bit per cycle.
module isqrt_seq #(
    parameter int unsigned IW = 19,
    parameter int unsigned OW = (IW + 1) / 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [IW-1:0] op_i,
    output logic          done_o,
    output logic [OW-1:0] root_o
);
    localparam int unsigned PW = 2 * OW;
    localparam int unsigned TW = OW + 4;
    localparam int unsigned CW = $clog2(OW + 1);

    logic [PW-1:0] op_q;
    logic [TW-1:0] rem_q;
    logic [OW-1:0] root_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [TW-1:0] rem_t;
    logic [TW-1:0] trial;

    assign done_o = done_q;
    assign root_o = root_q;

    // Bring down the next operand bit pair and form the trial subtrahend 4*root+1.
    always_comb begin
        rem_t = {rem_q[TW-3:0], op_q[PW-1 -: 2]};
        trial = TW'({root_q, 2'b01});
    end

    // Load on start, then one restoring step per cycle; done pulses after the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                op_q   <= PW'(op_i);
                rem_q  <= '0;
                root_q <= '0;
                cnt_q  <= CW'(OW);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                op_q <= {op_q[PW-3:0], 2'b00};
                if (rem_t >= trial) begin
                    rem_q  <= rem_t - trial;
                    root_q <= {root_q[OW-2:0], 1'b1};
                end else begin
                    rem_q  <= rem_t;
                    root_q <= {root_q[OW-2:0], 1'b0};
                end
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/distcalc_multi.sv
// Streaming multi-beat vector distance: per-lane |a-b| terms, beat reduction, accumulate, optional sqrt.
module distcalc_multi
    import distcalc_multi_pkg::*;
#(
    parameter int unsigned VARWIDTH   = 32,
    parameter int unsigned LANES      = 16,
    parameter int unsigned CHUNKS_MAX = 8,
    localparam int unsigned ACCWIDTH  = acc_width(VARWIDTH, LANES, CHUNKS_MAX)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [VARWIDTH*LANES-1:0] invec0,
    input  logic [VARWIDTH*LANES-1:0] invec1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACCWIDTH-1:0]       outval,
    output logic                      err
);
    localparam int unsigned SQW = sqrt_width(ACCWIDTH);
    localparam int unsigned TW  = 2 * VARWIDTH;
    localparam int unsigned VW  = VARWIDTH * LANES;
    localparam int unsigned CW  = $clog2(CHUNKS_MAX + 1);

    dm_state_e           state_q;
    dm_mode_e            mode_q;
    logic [CW-1:0]       cnt_q;
    logic                ovf_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [ACCWIDTH-1:0] outval_q;
    logic                err_q;

    logic [VW-1:0]       a0_q, b0_q;
    logic                v0_q, l0_q;
    logic [TW-1:0]       term_q [LANES];
    logic [TW-1:0]       term_d [LANES];
    logic                v1_q, l1_q;
    logic [ACCWIDTH-1:0] red_q, red_d;
    logic                v2_q, l2_q;
    logic [ACCWIDTH-1:0] acc_q, acc_d, res_d;

    logic                accept;
    logic                ovf_beat;
    logic                sq_start;
    logic                sq_done;
    logic [SQW-1:0]      sq_root;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign outval    = outval_q;
    assign err       = err_q;

    assign accept   = in_valid & in_ready_q;
    assign ovf_beat = (cnt_q == CW'(CHUNKS_MAX));
    assign sq_start = (state_q == ST_DRAIN) & v2_q & l2_q & (mode_q == DM_EUCLID);

    // Per-lane absolute difference, squared for the Euclidean metrics.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [VARWIDTH-1:0] a, b, d;
        assign a = a0_q[g*VARWIDTH +: VARWIDTH];
        assign b = b0_q[g*VARWIDTH +: VARWIDTH];
        assign d = (a >= b) ? a - b : b - a;
        assign term_d[g] = (mode_q == DM_MANHATTAN || mode_q == DM_CHEBYSHEV)
                         ? TW'(d) : TW'(d) * TW'(d);
    end

    // Beat reduction: max of lane terms for Chebyshev, sum otherwise.
    always_comb begin
        red_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mode_q == DM_CHEBYSHEV) begin
                if (ACCWIDTH'(term_q[i]) > red_d) red_d = ACCWIDTH'(term_q[i]);
            end else begin
                red_d = red_d + ACCWIDTH'(term_q[i]);
            end
        end
    end

    // Accumulator merge and the saturated result of an over-long vector.
    always_comb begin
        if (mode_q == DM_CHEBYSHEV) acc_d = (red_q > acc_q) ? red_q : acc_q;
        else                        acc_d = acc_q + red_q;
        res_d = ovf_q ? '1 : acc_d;
    end

    isqrt_seq #(
        .IW(ACCWIDTH),
        .OW(SQW)
    ) u_isqrt (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(sq_start),
        .op_i   (res_d),
        .done_o (sq_done),
        .root_o (sq_root)
    );

    // Control FSM, beat counting, pipeline stages and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            mode_q      <= DM_SQEUCLID;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            outval_q    <= '0;
            err_q       <= 1'b0;
            a0_q        <= '0;
            b0_q        <= '0;
            v0_q        <= 1'b0;
            l0_q        <= 1'b0;
            for (int i = 0; i < LANES; i++) term_q[i] <= '0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            red_q       <= '0;
            v2_q        <= 1'b0;
            l2_q        <= 1'b0;
            acc_q       <= '0;
        end else begin
            // Input capture; beats past CHUNKS_MAX enter as zeros so they contribute nothing.
            v0_q <= accept;
            l0_q <= accept & in_last;
            if (accept) begin
                a0_q <= ovf_beat ? '0 : invec0;
                b0_q <= ovf_beat ? '0 : invec1;
                if (cnt_q == '0) mode_q <= dm_mode_e'(mode);
                if (ovf_beat) ovf_q <= 1'b1;
                else          cnt_q <= cnt_q + CW'(1);
            end

            v1_q <= v0_q;
            l1_q <= l0_q;
            if (v0_q) term_q <= term_d;

            v2_q <= v1_q;
            l2_q <= l1_q;
            if (v1_q) red_q <= red_d;

            if (v2_q) acc_q <= acc_d;

            case (state_q)
                ST_ACC: begin
                    if (accept && in_last) begin
                        state_q    <= ST_DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (v2_q && l2_q) begin
                        if (mode_q == DM_EUCLID) begin
                            state_q <= ST_SQRT;
                        end else begin
                            state_q     <= ST_OUT;
                            out_valid_q <= 1'b1;
                            outval_q    <= res_d;
                            err_q       <= ovf_q;
                        end
                    end
                end
                ST_SQRT: begin
                    if (sq_done) begin
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                        outval_q    <= ACCWIDTH'(sq_root);
                        err_q       <= ovf_q;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q     <= ST_ACC;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        acc_q       <= '0;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

endmodule

// File: doc/distcalc_multi.md
# distcalc_multi

Streaming, multi-mode vector distance unit: the next generation of the Euclidean distance path, supporting vectors longer than the lane count. It accepts a vector pair as a burst of LANES-wide beats over a valid/ready handshake and accumulates per-lane terms across beats. It returns one distance per vector under a selectable metric: squared Euclidean, Manhattan, Euclidean (integer square root) or Chebyshev. It sits between the feature-vector buffer and the classifier's compare/sort logic.

## Interface
- VARWIDTH, 32, unsigned element width
- LANES, 16, elements per beat
- CHUNKS_MAX, 8, maximum beats per vector
- ACCWIDTH, 2*VARWIDTH+$clog2(LANES*CHUNKS_MAX), accumulator/result width (derived)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  2  00 sq-Euclid, 01 Manhattan, 10 Euclid (sqrt), 11 Chebyshev; sampled on first beat of a vector
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_last  in  1  marks final beat of the vector
- invec0, invec1  in  VARWIDTH*LANES  lane i at [i*VARWIDTH +: VARWIDTH]
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer accepts result
- outval  out  ACCWIDTH  distance (sqrt result zero-extended)
- err  out  1  vector exceeded CHUNKS_MAX beats; qualified by out_valid

## Operation
- States: ACC (accepting beats), DRAIN (pipeline flushing after last beat), SQRT (mode 10 only), OUT (holding result).
- Reset: state ACC, in_ready=1 once rst_n high, out_valid=0, outval=0, err=0, accumulator, beat counter and pipeline valids cleared.
- in_ready=1 only in ACC; a vector's results never overlap the next vector's beats.
- Per lane: d=|a-b| (VARWIDTH). Term: mode 00/10 d*d (2*VARWIDTH), 01 d, 11 d.
- Reduction per beat: sum of terms (modes 00/01/10) or max of terms (11); accumulator adds (or max-merges) into ACCWIDTH register.
- Accumulator and beat count cleared when a result is consumed; first beat of a vector latches mode.
- Beat count > CHUNKS_MAX: err set sticky for that vector, further beats accepted but ignored, outval forced to all ones (modes 00/01/11) or sqrt of all ones (10).
- in_last on first beat valid (single-beat vector).
- Mode 10: restoring integer sqrt, one result bit per cycle, floor(sqrt(acc)), SQW=(ACCWIDTH+1)/2 cycles.
- OUT: outval and err stable while out_valid & !out_ready; on handshake go to ACC, out_valid=0 next cycle.
- Reset asserted at any time: immediate return to reset values, partial vector discarded.

## Timing
- Pipeline: beat accepted at edge T -> lane terms registered T+1 -> beat reduction T+2 -> accumulator T+3.
- Modes 00/01/11: last beat at T -> out_valid=1 from edge T+3.
- Mode 10: out_valid=1 from edge T+4+SQW.
- Back-to-back beats: one per cycle in ACC, no bubbles.
- Next vector's first beat earliest one cycle after the result handshake.
- out_valid & out_ready same cycle as out_valid rises: accepted; in_ready=1 next cycle.

## Structure
- Shared package: mode encodings (DM_SQEUCLID, DM_MANHATTAN, DM_EUCLID, DM_CHEBYSHEV), state encoding, ACCWIDTH/SQW helper functions.
- One sub-module: isqrt_seq (start/done handshake, ACCWIDTH in, SQW out), reusable elsewhere.
- Lane subtract/square and reduction stay in-line (generate loop).

## Test plan
Bench parameters: VARWIDTH=8, LANES=4, CHUNKS_MAX=2, so ACCWIDTH=19 and SQW=10.
- Single beat, invec0 lanes {3,0,0,0}, invec1 {0,4,0,0}, in_last=1 -> mode 00 gives 25, 01 gives 7, 11 gives 4, each at T+3; mode 10 gives 5 at T+14.
- Two beats, {1,1,1,1} then {2,2,2,2} vs zeros, mode 00 -> 20; mode 01 -> 12; beats back-to-back with no stall.
- Three beats without in_last before the third -> err=1, outval=all ones (0x7FFFF); the next vector after the handshake gives err=0 and a correct result.
- out_ready held low 5 cycles after out_valid -> outval/err stable, in_ready=0 throughout; release -> in_ready=1 next cycle.
- mode changed mid-vector (00 on beat 1, 01 on beat 2) -> result uses 00 throughout.
- rst_n pulsed low after the first beat of a two-beat vector -> out_valid=0 and err=0 immediately; a fresh vector afterwards gives an uncorrupted result.
